// File: rtl/mmio_confreg.sv
// Data-side MMIO block: CLINT-style mtime/mtimecmp timer plus an optional buffered UART transmitter.
// The UART (TX FIFO, status register, drain FSM) is built only when MMIO_UART_EN is defined.
module mmio_confreg #(
    parameter int FIFO_DEPTH = 4,
    parameter int TX_DIV     = 1,
    parameter int TICK_DIV   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        conf_en,
    input  logic [7:0]  conf_wen,
    input  logic [63:0] conf_addr,
    input  logic [63:0] conf_wdata,
    output logic [63:0] conf_rdata,
    output logic        timer_int,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_ch
);

    localparam logic [63:0] ADDR_MTIMECMP  = 64'h0000_0000_0200_4000;
    localparam logic [63:0] ADDR_MTIME     = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] ADDR_UART_TX   = 64'h0000_0000_1000_0000;
    localparam logic [63:0] ADDR_UART_STAT = 64'h0000_0000_1000_0008;
    localparam int          PW             = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [63:0] addr;
    logic        rdEn;
    logic        wrEn;
    logic [63:0] rdataSel;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;

    assign addr = conf_addr & ~64'h7;
    assign rdEn = conf_en && (conf_wen == 8'h00);
    assign wrEn = conf_en && (conf_wen != 8'h00);

    function automatic logic [63:0] byteMerge(input logic [63:0] oldVal,
                                              input logic [63:0] newVal,
                                              input logic [7:0]  wen);
        logic [63:0] res;
        res = oldVal;
        for (int i = 0; i < 8; i++) begin
            if (wen[i]) res[8*i +: 8] = newVal[8*i +: 8];
        end
        return res;
    endfunction

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // A software write to MTIME replaces the tick entirely; unwritten bytes keep the pre-increment value.
    always_comb begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wrEn && addr == ADDR_MTIME) begin
            mtime_d = byteMerge(mtime_q, conf_wdata, conf_wen);
        end
        if (wrEn && addr == ADDR_MTIMECMP) begin
            mtimecmp_d = byteMerge(mtimecmp_q, conf_wdata, conf_wen);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            timer_int  <= 1'b0;
            conf_rdata <= '0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            timer_int  <= (mtime_q >= mtimecmp_q);
            if (rdEn) conf_rdata <= rdataSel;
        end
    end

`ifdef MMIO_UART_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

    typedef enum logic {
        TX_IDLE,
        TX_GAP
    } txState_t;

    logic [7:0]    fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   drops_q, drops_d;
    logic [7:0]    lastCh_q;
    txState_t      state_q, state_d;
    logic [CW-1:0] gap_q, gap_d;
    logic          push, pushOk, pop, full, empty;
    logic [63:0]   uartStat;

    assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign push   = wrEn && (addr == ADDR_UART_TX) && conf_wen[0];
    assign pushOk = push && !full;
    assign pop    = (state_q == TX_IDLE) && !empty;

    assign uart_out_valid = pop;
    assign uart_out_ch    = pop ? fifoMem_q[rdPtr_q] : lastCh_q;
    assign uartStat       = {32'h0, drops_q, 3'b000, 5'(count_q), 6'b000000, full, empty};

    always_comb begin
        count_d = count_q + (AW+1)'(pushOk) - (AW+1)'(pop);
        drops_d = drops_q;
        if (push && full && drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
    end

    // Drain FSM: the GAP state holds off the next pop so strobes are at least TX_DIV cycles apart.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            TX_IDLE: begin
                if (!empty && TX_DIV > 1) begin
                    state_d = TX_GAP;
                    gap_d   = CW'(TX_DIV - 1);
                end
            end
            TX_GAP: begin
                if (gap_q <= CW'(1)) state_d = TX_IDLE;
                else                 gap_d   = gap_q - 1'b1;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pushOk) fifoMem_q[wrPtr_q] <= conf_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            drops_q  <= '0;
            lastCh_q <= '0;
            state_q  <= TX_IDLE;
            gap_q    <= '0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop) begin
                rdPtr_q  <= rdPtr_q + 1'b1;
                lastCh_q <= fifoMem_q[rdPtr_q];
            end
            count_q <= count_d;
            drops_q <= drops_d;
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end
`else
    assign uart_out_valid = 1'b0;
    assign uart_out_ch    = 8'h00;
`endif

    always_comb begin
        rdataSel = '0;
        case (addr)
            ADDR_MTIMECMP:  rdataSel = mtimecmp_q;
            ADDR_MTIME:     rdataSel = mtime_q;
`ifdef MMIO_UART_EN
            ADDR_UART_STAT: rdataSel = uartStat;
`endif
            default:        rdataSel = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_confreg.sv
// Self-checking bench for mmio_confreg: directed test-plan scenarios plus randomized bus traffic,
// all compared against a transaction-level model of the timer and UART queue.
module tb_mmio_confreg;

    localparam int FIFO_DEPTH = 4;
    localparam int TX_DIV     = 3;
    localparam int TICK_DIV   = 2;

    localparam logic [63:0] A_MTIMECMP = 64'h0200_4000;
    localparam logic [63:0] A_MTIME    = 64'h0200_BFF8;
    localparam logic [63:0] A_TX       = 64'h1000_0000;
    localparam logic [63:0] A_STAT     = 64'h1000_0008;

`ifdef MMIO_UART_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        conf_en;
    logic [7:0]  conf_wen;
    logic [63:0] conf_addr;
    logic [63:0] conf_wdata;
    logic [63:0] conf_rdata;
    logic        timer_int;
    logic        uart_out_valid;
    logic [7:0]  uart_out_ch;

    mmio_confreg #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .TX_DIV    (TX_DIV),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .conf_en       (conf_en),
        .conf_wen      (conf_wen),
        .conf_addr     (conf_addr),
        .conf_wdata    (conf_wdata),
        .conf_rdata    (conf_rdata),
        .timer_int     (timer_int),
        .uart_out_valid(uart_out_valid),
        .uart_out_ch   (uart_out_ch)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state
    logic [63:0] mMtime, mMtimecmp, mRdata;
    logic        mTint;
    int          mPresc;
    logic [7:0]  mFifo[$];
    int          mDrops;
    int          mCool;
    logic [7:0]  mLastCh;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%h expected=0x%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        mMtime    = 64'd0;
        mMtimecmp = '1;
        mRdata    = 64'd0;
        mTint     = 1'b0;
        mPresc    = 0;
        mFifo.delete();
        mDrops    = 0;
        mCool     = 0;
        mLastCh   = 8'h00;
    endtask

    function automatic logic [63:0] merge(input logic [63:0] oldVal, input logic [63:0] newVal,
                                          input logic [7:0] wen);
        logic [63:0] r;
        r = oldVal;
        for (int i = 0; i < 8; i++) if (wen[i]) r[8*i +: 8] = newVal[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] modelRead(input logic [63:0] a);
        int sz;
        sz = mFifo.size();
        if (a == A_MTIMECMP) return mMtimecmp;
        if (a == A_MTIME)    return mMtime;
        if (UART_EN && a == A_STAT)
            return 64'(mDrops) * 65536 + 64'(sz) * 256 + ((sz == FIFO_DEPTH) ? 64'd2 : 64'd0)
                   + ((sz == 0) ? 64'd1 : 64'd0);
        return 64'd0;
    endfunction

    // One bus cycle: drive request, check UART outputs for this cycle, advance the model, check registered outputs.
    task automatic applyStimulus(input logic en, input logic [7:0] wen, input logic [63:0] addr,
                                 input logic [63:0] wdata);
        logic        expValid;
        logic [7:0]  expCh;
        logic [63:0] a;
        logic [63:0] nextTime;
        bit          isFull;
        conf_en    = en;
        conf_wen   = wen;
        conf_addr  = addr;
        conf_wdata = wdata;
        #1;
        expValid = UART_EN && (mFifo.size() > 0) && (mCool == 0);
        expCh    = expValid ? mFifo[0] : mLastCh;
        checkOutput("uart_valid", {63'd0, uart_out_valid}, {63'd0, expValid});
        checkOutput("uart_ch", {56'd0, uart_out_ch}, {56'd0, expCh});

        a = addr & ~64'h7;
        if (en && wen == 8'h00) mRdata = modelRead(a);
        mTint    = (mMtime >= mMtimecmp);
        nextTime = (mPresc == TICK_DIV - 1) ? mMtime + 64'd1 : mMtime;
        if (en && wen != 8'h00 && a == A_MTIME)    nextTime  = merge(mMtime, wdata, wen);
        if (en && wen != 8'h00 && a == A_MTIMECMP) mMtimecmp = merge(mMtimecmp, wdata, wen);
        mMtime = nextTime;
        mPresc = (mPresc + 1) % TICK_DIV;
        if (UART_EN) begin
            isFull = (mFifo.size() == FIFO_DEPTH);
            if (expValid) begin
                mLastCh = mFifo.pop_front();
                mCool   = TX_DIV - 1;
            end else if (mCool > 0) begin
                mCool--;
            end
            if (en && wen[0] && a == A_TX) begin
                if (isFull) mDrops = (mDrops < 65535) ? mDrops + 1 : 65535;
                else        mFifo.push_back(wdata[7:0]);
            end
        end

        @(posedge clk);
        @(negedge clk);
        checkOutput("timer_int", {63'd0, timer_int}, {63'd0, mTint});
        checkOutput("rdata", conf_rdata, mRdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 64'd0, 64'd0);
    endtask

    task automatic writeReg(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] wen);
        applyStimulus(1'b1, wen, addr, data);
    endtask

    task automatic readReg(input logic [63:0] addr);
        applyStimulus(1'b1, 8'h00, addr, 64'd0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic doReset();
        conf_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", {63'd0, uart_out_valid}, 64'd0);
        checkOutput("rst_tint", {63'd0, timer_int}, 64'd0);
        checkOutput("rst_rdata", conf_rdata, 64'd0);
        resetModel();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rd;
        logic [7:0]  rw;
        int          sel;
        rst_n      = 1'b0;
        conf_en    = 1'b0;
        conf_wen   = 8'h00;
        conf_addr  = 64'd0;
        conf_wdata = 64'd0;
        resetModel();
        #1;
        checkOutput("reset_rdata", conf_rdata, 64'd0);
        checkOutput("reset_tint", {63'd0, timer_int}, 64'd0);
        checkOutput("reset_valid", {63'd0, uart_out_valid}, 64'd0);
        checkOutput("reset_ch", {56'd0, uart_out_ch}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        readReg(A_MTIMECMP);
        checkOutput("mtimecmp_reset", conf_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(3);
        readReg(A_MTIME);

        writeReg(A_MTIMECMP, 64'h20, 8'hFF);
        writeReg(A_MTIME, 64'h1E, 8'hFF);
        idle(8);
        readReg(A_MTIME);
        writeReg(A_MTIMECMP, '1, 8'hFF);
        idle(3);

        writeReg(A_MTIME, 64'h1234, 8'hFF);
        writeReg(A_MTIME, 64'hAB, 8'h01);
        readReg(A_MTIME);
        checkOutput("mtime_partial", conf_rdata, 64'h12AB);

        writeReg(A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        idle(5);
        readReg(A_MTIME);

        writeReg(64'h1000_0010, 64'h55, 8'hFF);
        readReg(64'h1000_0010);
        checkOutput("unmapped_read", conf_rdata, 64'd0);
        readReg(A_TX);

        writeReg(A_TX, 64'h48, 8'h01);
        writeReg(A_TX, 64'h69, 8'h01);
        writeReg(A_TX, 64'h21, 8'h01);
        idle(12);
        readReg(A_STAT);
        checkOutput("stat_empty", conf_rdata, UART_EN ? 64'h1 : 64'h0);

        for (int i = 0; i < 7; i++) writeReg(A_TX, 64'(8'h30 + i), 8'h01);
        idle(30);
        readReg(A_STAT);
        checkOutput("stat_drop", conf_rdata, UART_EN ? 64'h1_0001 : 64'h0);

        writeReg(A_TX, 64'h41, 8'h01);
        writeReg(A_TX, 64'h42, 8'h01);
        writeReg(A_TX, 64'h43, 8'h01);
        doReset();
        idle(10);
        readReg(A_STAT);
        checkOutput("stat_after_rst", conf_rdata, UART_EN ? 64'h1 : 64'h0);

        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    ra = A_MTIMECMP;
                2, 3:    ra = A_MTIME;
                4, 5, 6: ra = A_TX;
                7, 8:    ra = A_STAT;
                default: ra = {$urandom(), $urandom()};
            endcase
            ra = ra | 64'($urandom_range(0, 7));
            rd = {$urandom(), $urandom()};
            if (ra[63:3] == A_MTIME[63:3] || ra[63:3] == A_MTIMECMP[63:3]) rd[63:12] = '0;
            rw = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom());
            if (ra[63:3] == A_TX[63:3] && rw != 8'h00) rw[0] = 1'b1;
            if ($urandom_range(0, 299) == 0) doReset();
            else applyStimulus(1'($urandom_range(0, 3) != 0), rw, ra, rd);
        end
        idle(20);
        readReg(A_STAT);
        readReg(A_MTIME);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
